// File: rtl/adder_stream_pkg.sv
// adder_stream_pkg: shared types for the adder_stream block.
//   op_e        - operation encoding carried on the 2-bit op field
//   stage_t     - per-stage flags {valid, sat}; the result width is a parameter
//   MAX_LATENCY - upper bound for the LATENCY parameter
package adder_stream_pkg;

  localparam int MAX_LATENCY = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ACC = 2'd2,
    OP_CLR = 2'd3
  } op_e;

  typedef struct packed {
    logic valid;
    logic sat;
  } stage_t;

endpackage

// File: rtl/adder_stream_if.sv
// adder_stream_if: operand input stream and result output stream.
//   in_valid/in_ready  - input handshake
//   A, B, op           - operands and operation (0 ADD, 1 SUB, 2 ACC, 3 CLR)
//   out_valid/out_ready- output handshake
//   X, sat             - DATA_WIDTH+1 result and clamp flag
// Modports: master drives operands and out_ready; slave is the adder.
interface adder_stream_if #(
  parameter int DATA_WIDTH = 4
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [1:0]            op;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH:0]   X;
  logic                  sat;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, X, sat
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, X, sat
  );
endinterface

// File: rtl/adder_stream_stage.sv
// adder_stream_stage: one pipeline register holding {valid, sat} and a result.
//   clk, rst_n - clock, asynchronous active-low reset
//   en         - advance enable (low while the pipeline is stalled)
//   d_flags/d_x- stage input
//   q_flags/q_x- stage output
module adder_stream_stage
  import adder_stream_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  stage_t           d_flags,
  input  logic [WIDTH-1:0] d_x,
  output stage_t           q_flags,
  output logic [WIDTH-1:0] q_x
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_flags <= '0;
      q_x     <= '0;
    end else if (en) begin
      q_flags <= d_flags;
      q_x     <= d_x;
    end
  end

endmodule

// File: rtl/adder_stream.sv
// adder_stream: pipelined add / subtract / accumulate with valid/ready streams.
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   bus   - adder_stream_if.slave (operand stream in, result stream out)
// Parameters: DATA_WIDTH operand width, LATENCY register stages (1..4).
// Define ADDER_STREAM_SAT_EN for unsigned saturation instead of wrap; sat
// reports the clamped beat. Without it sat is tied to 0.
module adder_stream
  import adder_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int LATENCY    = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  adder_stream_if.slave  bus
);

  localparam int XW = DATA_WIDTH + 1;

  op_e           op;
  logic          stall;
  logic          accept;
  logic [XW-1:0] acc;
  logic [XW-1:0] a_ext;
  logic [XW-1:0] b_ext;
  logic [XW-1:0] res_x;
  logic          res_sat;

  // Index 0 is the combinational result entering the first register;
  // index LATENCY is the output of the last register.
  stage_t        flags [LATENCY+1];
  logic [XW-1:0] xs    [LATENCY+1];

  assign op     = op_e'(bus.op);
  assign a_ext  = {1'b0, bus.A};
  assign b_ext  = {1'b0, bus.B};

  // A single global stall freezes every stage so bubbles never collapse.
  assign stall  = flags[LATENCY].valid && !bus.out_ready;
  assign accept = bus.in_valid && !stall;

  assign bus.in_ready  = !stall;
  assign bus.out_valid = flags[LATENCY].valid;
  assign bus.X         = xs[LATENCY];
  assign bus.sat       = flags[LATENCY].sat;

  always_comb begin
    res_x   = '0;
    res_sat = 1'b0;
    unique case (op)
      OP_ADD:  res_x = a_ext + b_ext;
      OP_SUB:  res_x = a_ext - b_ext;
      OP_ACC:  res_x = acc + a_ext;
      default: res_x = '0;
    endcase
`ifdef ADDER_STREAM_SAT_EN
    // Addends are non-negative, so a wrapped sum is smaller than an addend.
    unique case (op)
      OP_ADD: if (res_x < a_ext) begin res_x = '1; res_sat = 1'b1; end
      OP_SUB: if (b_ext > a_ext) begin res_x = '0; res_sat = 1'b1; end
      OP_ACC: if (res_x < acc)   begin res_x = '1; res_sat = 1'b1; end
      default: ;
    endcase
`endif
  end

  // ACC stores the (possibly clamped) new value; CLR's result is zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (accept && (op == OP_ACC || op == OP_CLR)) begin
      acc <= res_x;
    end
  end

  assign flags[0] = '{valid: accept, sat: res_sat};
  assign xs[0]    = res_x;

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    adder_stream_stage #(
      .WIDTH(XW)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (!stall),
      .d_flags (flags[g]),
      .d_x     (xs[g]),
      .q_flags (flags[g+1]),
      .q_x     (xs[g+1])
    );
  end

endmodule

// File: tb/tb_adder_stream.sv
module tb_adder_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  adder_stream_if #(.DATA_WIDTH(4)) bus2 ();
  adder_stream_if #(.DATA_WIDTH(4)) bus1 ();
  adder_stream_if #(.DATA_WIDTH(4)) bus4 ();

  adder_stream #(.DATA_WIDTH(4), .LATENCY(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  adder_stream #(.DATA_WIDTH(4), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  adder_stream #(.DATA_WIDTH(4), .LATENCY(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  // Scoreboard: one queue and one model accumulator per DUT (0: L2, 1: L1, 2: L4)
  logic [5:0] q [3][$];
  int         macc [3];

  function automatic logic [5:0] model(input int k, input logic [1:0] op,
                                       input logic [3:0] a, input logic [3:0] b);
    int   r;
    logic s = 1'b0;
    case (op)
      2'd0:    r = int'(a) + int'(b);
      2'd1:    r = int'(a) - int'(b);
      2'd2:    r = macc[k] + int'(a);
      default: r = 0;
    endcase
`ifdef ADDER_STREAM_SAT_EN
    if (r > 31) begin r = 31; s = 1'b1; end
    else if (r < 0) begin r = 0; s = 1'b1; end
`else
    r = r & 31;
`endif
    if (op >= 2'd2) macc[k] = r;
    return {s, 5'(r)};
  endfunction

  task automatic sb(input int k, input logic iv, input logic ir, input logic [1:0] op,
                    input logic [3:0] a, input logic [3:0] b, input logic ov,
                    input logic ordy, input logic [4:0] x, input logic s);
    logic [5:0] e;
    if (!rst_n) begin
      q[k].delete();
      macc[k] = 0;
      return;
    end
    if (ov && ordy) begin
      n_cmp++;
      assert (q[k].size() != 0)
      else begin
        n_bad++;
        $error("FAIL unexpected_beat dut%0d: observed x=%0d sat=%0b, expected no beat", k, x, s);
      end
      if (q[k].size() != 0) begin
        e = q[k].pop_front();
        n_cmp++;
        assert ({s, x} === e)
        else begin
          n_bad++;
          $error("FAIL beat dut%0d: observed x=%0d sat=%0b, expected x=%0d sat=%0b",
                 k, x, s, e[4:0], e[5]);
        end
      end
    end
    if (iv && ir) q[k].push_back(model(k, op, a, b));
  endtask

  always @(negedge clk) begin
    sb(0, bus2.in_valid, bus2.in_ready, bus2.op, bus2.A, bus2.B, bus2.out_valid, bus2.out_ready, bus2.X, bus2.sat);
    sb(1, bus1.in_valid, bus1.in_ready, bus1.op, bus1.A, bus1.B, bus1.out_valid, bus1.out_ready, bus1.X, bus1.sat);
    sb(2, bus4.in_valid, bus4.in_ready, bus4.op, bus4.A, bus4.B, bus4.out_valid, bus4.out_ready, bus4.X, bus4.sat);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send2(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int guard = 0;
    bus2.in_valid = 1'b1;
    bus2.op = op;
    bus2.A = a;
    bus2.B = b;
    do begin
      @(negedge clk);
      guard++;
    end while (!bus2.in_ready && guard < 50);
    chk("accept_timeout", 32'(bus2.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus2.in_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand1();
    int sent = 0;
    int guard = 0;
    while (sent < 1000 && guard < 20000) begin
      bus1.in_valid  = ($urandom_range(0, 3) != 0);
      bus1.op        = 2'($urandom);
      bus1.A         = 4'($urandom);
      bus1.B         = 4'($urandom);
      bus1.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus1.in_valid && bus1.in_ready) sent++;
      @(posedge clk);
      #1;
      guard++;
    end
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    chk("rand_l1_sent", 32'(sent), 32'd1000);
  endtask

  task automatic rand4();
    int sent = 0;
    int guard = 0;
    while (sent < 1000 && guard < 20000) begin
      bus4.in_valid  = ($urandom_range(0, 3) != 0);
      bus4.op        = 2'($urandom);
      bus4.A         = 4'($urandom);
      bus4.B         = 4'($urandom);
      bus4.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus4.in_valid && bus4.in_ready) sent++;
      @(posedge clk);
      #1;
      guard++;
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    chk("rand_l4_sent", 32'(sent), 32'd1000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus2.in_valid = 1'b0; bus2.op = '0; bus2.A = '0; bus2.B = '0; bus2.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.op = '0; bus1.A = '0; bus1.B = '0; bus1.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.op = '0; bus4.A = '0; bus4.B = '0; bus4.out_ready = 1'b1;

    // Reset state
    #12;
    chk("reset_out_valid", 32'(bus2.out_valid), 32'd0);
    chk("reset_x", 32'(bus2.X), 32'd0);
    chk("reset_in_ready", 32'(bus2.in_ready), 32'd1);
    chk("reset_sat", 32'(bus2.sat), 32'd0);
    chk("reset_out_valid_l4", 32'(bus4.out_valid), 32'd0);

    // Idle after release
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_out_valid", 32'(bus2.out_valid), 32'd0);
    end

    // ADD 15+15 with latency check
    settle(1);
    send2(2'd0, 4'd15, 4'd15);
    @(negedge clk);
    chk("add_early_valid", 32'(bus2.out_valid), 32'd0);
    @(negedge clk);
    chk("add_valid", 32'(bus2.out_valid), 32'd1);
    chk("add_x", 32'(bus2.X), 32'd30);

    // SUB 2-3 wraps (or clamps when saturating)
    settle(1);
    send2(2'd1, 4'd2, 4'd3);
    settle(3);

    // Accumulate chain, back-to-back
    send2(2'd3, 4'd5, 4'd5);
    send2(2'd2, 4'd9, 4'd7);
    send2(2'd2, 4'd9, 4'd0);
    send2(2'd2, 4'd9, 4'd3);
    send2(2'd2, 4'd9, 4'd1);
    send2(2'd2, 4'd1, 4'd0);
    settle(4);

    // Backpressure with pipeline full
    bus2.out_ready = 1'b0;
    send2(2'd0, 4'd1, 4'd1);
    send2(2'd0, 4'd2, 4'd2);
    bus2.in_valid = 1'b1; bus2.op = 2'd0; bus2.A = 4'd3; bus2.B = 4'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus2.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus2.out_valid), 32'd1);
      chk("bp_x_frozen", 32'(bus2.X), 32'd2);
    end
    @(posedge clk);
    #1;
    bus2.out_ready = 1'b1;
    send2(2'd0, 4'd3, 4'd3);
    settle(4);

    // Reset mid-stream with acc=18 and two beats in flight
    send2(2'd3, 4'd0, 4'd0);
    send2(2'd2, 4'd9, 4'd0);
    send2(2'd2, 4'd9, 4'd0);
    settle(4);
    bus2.out_ready = 1'b0;
    send2(2'd0, 4'd1, 4'd2);
    send2(2'd0, 4'd3, 4'd4);
    #3;
    chk("pre_reset_out_valid", 32'(bus2.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", 32'(bus2.out_valid), 32'd0);
    chk("async_reset_in_ready", 32'(bus2.in_ready), 32'd1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus2.out_ready = 1'b1;
    send2(2'd2, 4'd1, 4'd0);
    @(negedge clk);
    @(negedge clk);
    chk("post_reset_acc_x", 32'(bus2.X), 32'd1);
    settle(4);

    // Random traffic at LATENCY=1 and LATENCY=4
    fork
      rand1();
      rand4();
    join
    settle(12);
    chk("drain_l2", 32'(q[0].size()), 32'd0);
    chk("drain_l1", 32'(q[1].size()), 32'd0);
    chk("drain_l4", 32'(q[2].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
